input_pkt_fifo: RTL

- Packet-aware synchronous input FIFO for the multi-port cache ingress, with sop/eop framing and store-and-forward behaviour.
- A packet becomes visible to the reader only after its eop word is committed.
- Partial packets that are aborted or overflow are rewound and counted, never forwarded.
- Read side is first-word-fall-through and exposes packet and word occupancy to the downstream arbiter.

---
 rtl/input_fifo_pkg.sv | 9 +
 rtl/pkt_fifo_mem.sv | 24 ++
 rtl/input_pkt_fifo.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/input_fifo_pkg.sv
// Shared types and constants for the packet-aware ingress FIFO.
package input_fifo_pkg;

  typedef enum logic [1:0] {IDLE, PKT, DISCARD} wr_state_e;

  localparam int unsigned FLAG_W     = 2;
  localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/pkt_fifo_mem.sv
// Word storage for the ingress FIFO: synchronous write, asynchronous read.
module pkt_fifo_mem #(
  parameter int unsigned Width     = 18,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [2**AddrWidth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/input_pkt_fifo.sv
// Store-and-forward packet FIFO: words become readable only once their packet's eop commits;
// aborted or overflowing partial packets are rewound to the commit pointer and counted.
module input_pkt_fifo
  import input_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned AF_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_sop,
  input  logic                  din_eop,
  input  logic                  wr_en,
  input  logic                  wr_abort,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_sop,
  output logic                  dout_eop,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  pkt_avail,
  output logic [ADDR_WIDTH:0]   pkt_cnt,
  output logic [ADDR_WIDTH:0]   data_cnt,
  output logic                  drop_pulse,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned PtrW  = ADDR_WIDTH + 1;
  localparam int unsigned MemW  = DATA_WIDTH + FLAG_W;
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW-1:0] DepthP = PtrW'(Depth);
  localparam logic [PtrW-1:0] AfP    = PtrW'(AF_MARGIN);

  wr_state_e             state_q, state_d;
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       cptr_q, cptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [PtrW-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  drop_pulse_q;
  logic [MemW-1:0]       last_q, last_d;

  logic                  mem_we;
  logic [PtrW-1:0]       mem_wptr;
  logic [MemW-1:0]       mem_rdata;
  logic                  commit;
  logic                  drop;
  logic                  pop;
  logic                  pop_eop;
  logic [PtrW-1:0]       free_words;

  pkt_fifo_mem #(
    .Width     (MemW),
    .AddrWidth (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_wptr[ADDR_WIDTH-1:0]),
    .wdata_i ({din_sop, din_eop, din}),
    .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (mem_rdata)
  );

  // Flags come from registered pointers only, so a same-cycle read never frees room for a write.
  assign full        = (wptr_q ^ rptr_q) == {1'b1, {ADDR_WIDTH{1'b0}}};
  assign empty       = (rptr_q == cptr_q);
  assign data_cnt    = wptr_q - rptr_q;
  assign free_words  = DepthP - data_cnt;
  assign almost_full = (free_words <= AfP);
  assign pkt_cnt     = pkt_cnt_q;
  assign pkt_avail   = (pkt_cnt_q != '0);
  assign drop_pulse  = drop_pulse_q;
  assign drop_cnt    = drop_cnt_q;

  assign {dout_sop, dout_eop, dout} = empty ? last_q : mem_rdata;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    cptr_d   = cptr_q;
    mem_we   = 1'b0;
    mem_wptr = wptr_q;
    commit   = 1'b0;
    drop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!wr_abort && wr_en) begin
          if (!din_sop) begin
            drop = 1'b1;
          end else if (full) begin
            drop = 1'b1;
            if (!din_eop) state_d = DISCARD;
          end else begin
            mem_we = 1'b1;
            wptr_d = wptr_q + PtrOne;
            if (din_eop) begin
              cptr_d = wptr_q + PtrOne;
              commit = 1'b1;
            end else begin
              state_d = PKT;
            end
          end
        end
      end
      PKT: begin
        if (wr_abort) begin
          wptr_d  = cptr_q;
          drop    = 1'b1;
          state_d = IDLE;
        end else if (wr_en) begin
          if (din_sop) begin
            // Restart at the commit point; a partial packet in flight means cptr cannot be full.
            drop     = 1'b1;
            mem_we   = 1'b1;
            mem_wptr = cptr_q;
            wptr_d   = cptr_q + PtrOne;
            if (din_eop) begin
              cptr_d  = cptr_q + PtrOne;
              commit  = 1'b1;
              state_d = IDLE;
            end
          end else if (full) begin
            wptr_d  = cptr_q;
            drop    = 1'b1;
            state_d = din_eop ? IDLE : DISCARD;
          end else begin
            mem_we = 1'b1;
            wptr_d = wptr_q + PtrOne;
            if (din_eop) begin
              cptr_d  = wptr_q + PtrOne;
              commit  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      DISCARD: begin
        if (wr_abort || (wr_en && din_eop)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop     = rd_en && !empty;
    pop_eop = pop && mem_rdata[DATA_WIDTH];
    rptr_d  = pop ? rptr_q + PtrOne : rptr_q;
    last_d  = pop ? mem_rdata : last_q;

    pkt_cnt_d = pkt_cnt_q;
    if (commit && !pop_eop) begin
      pkt_cnt_d = pkt_cnt_q + PtrOne;
    end else if (!commit && pop_eop) begin
      pkt_cnt_d = pkt_cnt_q - PtrOne;
    end

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      cptr_q       <= '0;
      rptr_q       <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      last_q       <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      cptr_q       <= cptr_d;
      rptr_q       <= rptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop;
      last_q       <= last_d;
    end
  end

endmodule
